// File: rtl/cpu_pkg.sv
// Shared types for the dual-issue control path: FSM state encoding and
// architectural field widths.
package cpu_pkg;

  localparam int REG_W   = 3;
  localparam int STALL_W = 16;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SPLIT   = 3'd1,
    LDUSE   = 3'd2,
    MEMWAIT = 3'd3,
    FLUSH   = 3'd4,
    EXC     = 3'd5
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard comparators for one decoded instruction pair plus the
// register tag of a load issued in the previous cycle.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             i_regWrite1,
  input  logic             i_regWrite2,
  input  logic [REG_W-1:0] i_dst1,
  input  logic [REG_W-1:0] i_src1a,
  input  logic [REG_W-1:0] i_src1b,
  input  logic [REG_W-1:0] i_dst2,
  input  logic [REG_W-1:0] i_src2a,
  input  logic [REG_W-1:0] i_src2b,
  input  logic             i_ldValid,
  input  logic [REG_W-1:0] i_ldTag,
  output logic             o_rawIntra,
  output logic             o_wawIntra,
  output logic             o_loadUse
);

  // Slot 1 reading dst2 is harmless: reads within a pair precede its writes.
  assign o_rawIntra = i_regWrite1 && ((i_dst1 == i_src2a) || (i_dst1 == i_src2b));
  assign o_wawIntra = i_regWrite1 && i_regWrite2 && (i_dst1 == i_dst2);
  assign o_loadUse  = i_ldValid && ((i_src1a == i_ldTag) || (i_src1b == i_ldTag) ||
                                    (i_src2a == i_ldTag) || (i_src2b == i_ldTag));

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue ID->EX controller: splits dependent pairs, inserts load-use
// bubbles, waits on data memory, flushes on jumps/taken branches, raises exceptions.
module issue_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid,
  input  logic               regWrite1,
  input  logic               regWrite2,
  input  logic               memRd,
  input  logic               memWr,
  input  logic               branch,
  input  logic               jump,
  input  logic               invalid1,
  input  logic               invalid2,
  input  logic [REG_W-1:0]   dst1,
  input  logic [REG_W-1:0]   src1a,
  input  logic [REG_W-1:0]   src1b,
  input  logic [REG_W-1:0]   dst2,
  input  logic [REG_W-1:0]   src2a,
  input  logic [REG_W-1:0]   src2b,
  input  logic               brTaken,
  input  logic               memReady,
  output logic               issue1,
  output logic               issue2,
  output logic               stallIF,
  output logic               flushID,
  output logic               memReq,
  output logic               excValid,
  output logic               excSlot,
  output logic [2:0]         state,
  output logic [STALL_W-1:0] stallCount
);

  state_t             r_state;
  state_t             w_next;
  state_t             w_cur;
  logic               r_memReq;
  logic               r_excSlot;
  logic               r_ldValid;
  logic               r_brPend;
  logic [REG_W-1:0]   r_ldTag;
  logic [STALL_W-1:0] r_stallCount;
  logic               w_raw;
  logic               w_waw;
  logic               w_loadUse;
  logic               w_excEnter;

  hazard_detect u_hazard (
    .i_regWrite1 (regWrite1),
    .i_regWrite2 (regWrite2),
    .i_dst1      (dst1),
    .i_src1a     (src1a),
    .i_src1b     (src1b),
    .i_dst2      (dst2),
    .i_src2a     (src2a),
    .i_src2b     (src2b),
    .i_ldValid   (r_ldValid),
    .i_ldTag     (r_ldTag),
    .o_rawIntra  (w_raw),
    .o_wawIntra  (w_waw),
    .o_loadUse   (w_loadUse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_next;
  end

  // Only RUN/SPLIT/FLUSH/EXC persist in r_state; MEMWAIT and LDUSE are
  // reported through w_cur for the cycles they stall.
  always_comb begin
    issue1     = 1'b0;
    issue2     = 1'b0;
    stallIF    = 1'b0;
    flushID    = 1'b0;
    excValid   = 1'b0;
    w_excEnter = 1'b0;
    w_cur      = r_state;
    w_next     = r_state;
    if (!reset_n) begin
      w_cur  = RUN;
      w_next = RUN;
    end else if (r_brPend && brTaken) begin
      w_cur   = FLUSH;
      flushID = 1'b1;
      w_next  = RUN;
    end else if (r_memReq && !memReady) begin
      w_cur   = MEMWAIT;
      stallIF = 1'b1;
    end else begin
      case (r_state)
        EXC: begin
          if (r_memReq) begin
            stallIF = 1'b1;
          end else begin
            excValid = 1'b1;
            flushID  = 1'b1;
            w_next   = RUN;
          end
        end
        FLUSH: begin
          flushID = 1'b1;
          w_next  = RUN;
        end
        SPLIT: begin
          issue2  = 1'b1;
          stallIF = 1'b1;
          w_next  = RUN;
        end
        default: begin
          w_next = RUN;
          if (valid) begin
            if (invalid1 || invalid2) begin
              w_excEnter = 1'b1;
              w_next     = EXC;
            end else if (w_loadUse) begin
              w_cur   = LDUSE;
              stallIF = 1'b1;
            end else if (w_raw || w_waw) begin
              issue1  = 1'b1;
              stallIF = 1'b1;
              w_next  = SPLIT;
            end else begin
              issue1 = 1'b1;
              issue2 = 1'b1;
            end
          end
        end
      endcase
      // Pair-level control ops belong to slot 2 and take effect when it issues.
      if (issue2 && jump) w_next = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_memReq     <= 1'b0;
      r_excSlot    <= 1'b0;
      r_ldValid    <= 1'b0;
      r_brPend     <= 1'b0;
      r_stallCount <= '0;
    end else begin
      if (issue2 && (memRd || memWr)) r_memReq <= 1'b1;
      else if (memReady)              r_memReq <= 1'b0;
      if (w_excEnter) r_excSlot <= ~invalid1;
      if (stallIF && (r_stallCount != '1)) r_stallCount <= r_stallCount + STALL_W'(1);
      r_ldValid <= issue2 && memRd;
      r_brPend  <= issue2 && branch;
    end
  end

  always_ff @(posedge clk) begin
    r_ldTag <= dst2;
  end

  assign memReq     = r_memReq;
  assign excSlot    = r_excSlot;
  assign stallCount = r_stallCount;
  assign state      = w_cur;

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomised and directed stimulus for issue_ctrl, scored cycle by cycle
// against a behavioural model of the issue rules.
module tb_issue_ctrl;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             valid, regWrite1, regWrite2, memRd, memWr, branch, jump;
  logic             invalid1, invalid2, brTaken, memReady;
  logic [REG_W-1:0] dst1, src1a, src1b, dst2, src2a, src2b;
  logic             issue1, issue2, stallIF, flushID, memReq, excValid, excSlot;
  logic [2:0]       state;
  logic [15:0]      stallCount;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit   m_half, m_jflush, m_excPend, m_excSlot, m_memBusy, m_brLast;
  int   m_ldReg, m_stalls;
  bit   e_i1, e_i2, e_st, e_fl, e_ev;
  logic [2:0] e_state;
  int   e_kind;

  issue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .regWrite1(regWrite1), .regWrite2(regWrite2), .memRd(memRd), .memWr(memWr),
    .branch(branch), .jump(jump), .invalid1(invalid1), .invalid2(invalid2),
    .dst1(dst1), .src1a(src1a), .src1b(src1b), .dst2(dst2), .src2a(src2a), .src2b(src2b),
    .brTaken(brTaken), .memReady(memReady),
    .issue1(issue1), .issue2(issue2), .stallIF(stallIF), .flushID(flushID),
    .memReq(memReq), .excValid(excValid), .excSlot(excSlot),
    .state(state), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_half = 0; m_jflush = 0; m_excPend = 0; m_excSlot = 0;
    m_memBusy = 0; m_brLast = 0; m_ldReg = -1; m_stalls = 0;
  endtask

  function automatic bit reads_reg(int r);
    return (int'(src1a) == r) || (int'(src1b) == r) || (int'(src2a) == r) || (int'(src2b) == r);
  endfunction

  // Expected behaviour for this cycle, highest-priority rule first.
  task automatic model_eval();
    e_i1 = 0; e_i2 = 0; e_st = 0; e_fl = 0; e_ev = 0; e_state = RUN;
    if (m_brLast && brTaken) begin
      e_kind = 0; e_fl = 1; e_state = FLUSH;
    end else if (m_memBusy && !memReady) begin
      e_kind = 1; e_st = 1; e_state = MEMWAIT;
    end else if (m_excPend) begin
      e_kind = 2; e_state = EXC;
      if (m_memBusy) e_st = 1;
      else begin e_ev = 1; e_fl = 1; end
    end else if (m_jflush) begin
      e_kind = 3; e_fl = 1; e_state = FLUSH;
    end else if (m_half) begin
      e_kind = 4; e_i2 = 1; e_st = 1; e_state = SPLIT;
    end else if (!valid) begin
      e_kind = 5;
    end else if (invalid1 || invalid2) begin
      e_kind = 6;
    end else if (m_ldReg >= 0 && reads_reg(m_ldReg)) begin
      e_kind = 7; e_st = 1; e_state = LDUSE;
    end else if (regWrite1 && (dst1 == src2a || dst1 == src2b || (regWrite2 && dst1 == dst2))) begin
      e_kind = 8; e_i1 = 1; e_st = 1;
    end else begin
      e_kind = 9; e_i1 = 1; e_i2 = 1;
    end
  endtask

  task automatic model_update();
    if (e_st && m_stalls < 65535) m_stalls++;
    if (e_i2 && (memRd || memWr)) m_memBusy = 1;
    else if (memReady)            m_memBusy = 0;
    m_ldReg  = (e_i2 && memRd) ? int'(dst2) : -1;
    m_brLast = e_i2 && branch;
    case (e_kind)
      0: begin m_half = 0; m_jflush = 0; m_excPend = 0; end
      2: if (e_ev) m_excPend = 0;
      3: m_jflush = 0;
      4: m_half = 0;
      6: begin m_excPend = 1; m_excSlot = !invalid1; end
      8: m_half = 1;
      default: ;
    endcase
    if (e_i2 && jump) m_jflush = 1;
  endtask

  task automatic run_cycle();
    #2;
    model_eval();
    check("issue1",     32'(issue1),     32'(e_i1));
    check("issue2",     32'(issue2),     32'(e_i2));
    check("stallIF",    32'(stallIF),    32'(e_st));
    check("flushID",    32'(flushID),    32'(e_fl));
    check("excValid",   32'(excValid),   32'(e_ev));
    check("state",      32'(state),      32'(e_state));
    check("memReq",     32'(memReq),     32'(m_memBusy));
    check("excSlot",    32'(excSlot),    32'(m_excSlot));
    check("stallCount", 32'(stallCount), 32'(m_stalls));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 0; regWrite1 = 0; regWrite2 = 0; memRd = 0; memWr = 0;
    branch = 0; jump = 0; invalid1 = 0; invalid2 = 0;
    dst1 = 0; src1a = 0; src1b = 0; dst2 = 0; src2a = 0; src2b = 0;
    brTaken = 0; memReady = 1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    32'(state),      32'(RUN));
    check({tag, "_memReq"},   32'(memReq),     32'(0));
    check({tag, "_stallCnt"}, 32'(stallCount), 32'(0));
    check({tag, "_excSlot"},  32'(excSlot),    32'(0));
    check({tag, "_outs"},     32'({issue1, issue2, stallIF, flushID, excValid}), 32'(0));
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check_reset_values("rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic rand_inputs();
    valid     = ($urandom_range(0, 9) < 8);
    regWrite1 = 1'($urandom_range(0, 1));
    regWrite2 = 1'($urandom_range(0, 1));
    memRd     = ($urandom_range(0, 9) < 2);
    memWr     = ($urandom_range(0, 9) == 0);
    branch    = ($urandom_range(0, 9) < 2);
    jump      = ($urandom_range(0, 19) == 0);
    invalid1  = ($urandom_range(0, 49) == 0);
    invalid2  = ($urandom_range(0, 49) == 0);
    dst1      = 3'($urandom_range(0, 3));
    src1a     = 3'($urandom_range(0, 7));
    src1b     = 3'($urandom_range(0, 7));
    dst2      = 3'($urandom_range(0, 3));
    src2a     = 3'($urandom_range(0, 3));
    src2b     = 3'($urandom_range(0, 7));
    brTaken   = 1'($urandom_range(0, 1));
    memReady  = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    idle();
    model_reset();
    do_reset();

    // intra-pair RAW: slot 1 then slot 2
    idle(); valid = 1; regWrite1 = 1; dst1 = 3; src2a = 3;
    #1;
    check("raw_c0", 32'({issue1, issue2, stallIF}), 32'(3'b101));
    run_cycle();
    #1;
    check("raw_c1_issue", 32'({issue1, issue2}), 32'(2'b01));
    check("raw_c1_cnt",   32'(stallCount), 32'(1));
    run_cycle();
    idle(); run_cycle();

    // load-use bubble
    do_reset();
    idle(); valid = 1; memRd = 1; regWrite2 = 1; dst2 = 5;
    run_cycle();
    idle(); valid = 1; src1b = 5; dst1 = 1; dst2 = 2;
    #1;
    check("ldu_bubble", 32'({issue1, issue2, stallIF}), 32'(3'b001));
    check("ldu_state",  32'(state), 32'(LDUSE));
    run_cycle();
    #1;
    check("ldu_after", 32'({issue1, issue2}), 32'(2'b11));
    run_cycle();
    idle(); run_cycle();

    // store with memory wait of three cycles
    do_reset();
    idle(); valid = 1; memWr = 1;
    run_cycle();
    idle(); memReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_req",   32'({memReq, stallIF}), 32'(2'b11));
      check("mw_state", 32'(state), 32'(MEMWAIT));
      run_cycle();
    end
    memReady = 1;
    #1;
    check("mw_cnt", 32'(stallCount), 32'(3));
    run_cycle();
    run_cycle();

    // taken branch
    do_reset();
    idle(); valid = 1; branch = 1;
    run_cycle();
    idle(); valid = 1; brTaken = 1; dst1 = 1; dst2 = 2;
    #1;
    check("br_flush", 32'({flushID, issue1, issue2}), 32'(3'b100));
    check("br_state", 32'(state), 32'(FLUSH));
    run_cycle();
    idle();
    #1;
    check("br_after", 32'({flushID, state}), 32'({1'b0, RUN}));
    run_cycle();

    // exception behind a pending load
    do_reset();
    idle(); valid = 1; memRd = 1; dst2 = 2;
    run_cycle();
    idle(); valid = 1; invalid2 = 1; memReady = 0;
    run_cycle();
    run_cycle();
    memReady = 1;
    #1;
    check("exc_wait", 32'(excValid), 32'(0));
    run_cycle();
    idle();
    #1;
    check("exc_pulse", 32'({excValid, flushID, excSlot, memReq}), 32'(4'b1110));
    run_cycle();
    #1;
    check("exc_once", 32'(excValid), 32'(0));
    run_cycle();

    // asynchronous reset during a memory wait
    do_reset();
    idle(); valid = 1; memWr = 1;
    run_cycle();
    idle(); valid = 1; invalid1 = 1; memReady = 0;
    run_cycle();
    #2;
    reset_n = 0;
    #1;
    check_reset_values("rst_mw");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    idle();
    for (int i = 0; i < 3; i++) run_cycle();

    // randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rand_inputs();
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port valid, input, 1: decoded instruction pair present in ID.
REQ-004 SHALL have decode inputs regWrite1, regWrite2, memRd, memWr, branch, jump, invalid1, invalid2, all input, 1, produced by the pair decoder.
REQ-005 SHALL have register inputs dst1, src1a, src1b, dst2, src2a, src2b, each input, 3: slot register fields.
REQ-006 SHALL have port brTaken, input, 1: branch issued last cycle resolved taken in EX.
REQ-007 SHALL have port memReady, input, 1: data memory completes the current access.
REQ-008 SHALL have outputs issue1, issue2, 1 each: slot advances ID->EX this cycle.
REQ-009 SHALL have outputs stallIF, flushID, memReq, excValid, excSlot, 1 each; state, 3; stallCount, 16.

Function
REQ-010 SHALL implement FSM states RUN, SPLIT, LDUSE, MEMWAIT, FLUSH, EXC.
REQ-011 In RUN with valid and no hazard, SHALL assert issue1 and issue2 in the same cycle.
REQ-012 Intra-pair RAW (regWrite1 and dst1 equals src2a or src2b) or WAW (regWrite1, regWrite2, dst1==dst2) SHALL assert issue1 only, stallIF, and enter SPLIT.
REQ-013 In SPLIT, SHALL assert issue2 only, hold stallIF, and return to RUN next cycle.
REQ-014 Slot-1 reads of dst2 in the same pair SHALL NOT be a hazard; reads precede writes within a pair.
REQ-015 SHALL register a pending-load tag (memRd issued, dst2) for one cycle; next pair reading that tag in any source SHALL issue nothing, assert stallIF, and take LDUSE for exactly one bubble cycle.
REQ-016 memReq SHALL assert the cycle after an issued memRd or memWr and stay high until memReady; while high and memReady low, SHALL be in MEMWAIT with issue1=issue2=0 and stallIF=1.
REQ-017 jump issued SHALL cause FLUSH next cycle: flushID=1 for one cycle, no issue.
REQ-018 brTaken high the cycle after a branch issue SHALL override the current cycle's issue (issue1=issue2=0), pulse flushID, enter FLUSH for one cycle; brTaken at any other time SHALL be ignored.
REQ-019 valid with invalid1 or invalid2 SHALL issue neither slot and enter EXC; excSlot=0 if invalid1 else 1.
REQ-020 EXC SHALL wait until memReq is low, then pulse excValid one cycle with excSlot held, flushID=1 that cycle, and return to RUN.
REQ-021 Priority when simultaneous: reset > brTaken flush > MEMWAIT > EXC > LDUSE > SPLIT > normal issue.
REQ-022 stallCount SHALL increment each cycle stallIF=1, saturating at 16'hFFFF.
REQ-023 valid low in RUN SHALL produce no issue and no stallIF.
REQ-024 Outputs issue1, issue2, stallIF, flushID, excValid SHALL be combinational from state and inputs; memReq, excSlot, stallCount registered.

Reset
REQ-025 reset_n low SHALL immediately force state=RUN, memReq=0, excSlot=0, stallCount=0, pending-load tag clear; issue/stall/flush/excValid deassert.
REQ-026 Reset asserted mid-MEMWAIT or mid-EXC SHALL abandon the access/exception with no excValid pulse.

Structure
REQ-027 State encodings and the 3-bit register-index width SHALL live in shared package cpu_pkg.
REQ-028 Hazard comparison SHALL be one sub-module hazard_detect (combinational: pair fields + pending tag in, rawIntra/wawIntra/loadUse out).

Verification
REQ-029 Pair dst1=3 regWrite1, src2a=3 -> cycle0 issue1=1 issue2=0 stallIF=1; cycle1 issue2=1; stallCount=1.
REQ-030 Load dst2=5, next pair src1b=5 -> one bubble (issue1=issue2=0, state LDUSE), then both issue.
REQ-031 Store with memReady low 3 cycles -> memReq high 3 cycles, stallIF high 3 cycles, stallCount=3.
REQ-032 Branch issued, brTaken=1 next cycle -> flushID one cycle, no issue that cycle, RUN after.
REQ-033 invalid2=1 while load pending with memReady delayed 2 cycles -> excValid pulses once after memReq drops, excSlot=1.
REQ-034 reset_n low during MEMWAIT -> outputs at reset values same cycle, no excValid, stallCount=0.
